// File: rtl/mem_copy_engine.sv
// Block-copy bus initiator for the single-port word RAM: reads SRC+idx, then writes DST+idx, one word at a time.
// Optional MEM_COPY_FILL_EN adds a pattern-fill mode (i_fill / i_fill_pattern) that skips the read phase.
module mem_copy_engine #(
  parameter int DEPTH = 1024,
  parameter int LEN_W = 11
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [31:0]      i_src_addr,
  input  logic [31:0]      i_dst_addr,
  input  logic [LEN_W-1:0] i_length,
`ifdef MEM_COPY_FILL_EN
  input  logic             i_fill,
  input  logic [31:0]      i_fill_pattern,
`endif
  output logic [31:0]      o_mem_address,
  output logic [31:0]      o_mem_write_data,
  output logic             o_mem_write,
  output logic             o_mem_read,
  input  logic [31:0]      i_mem_read_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error
);

  // state | meaning
  // IDLE  | waiting for start; RAM port outputs held at 0
  // RD    | mem_read asserted at src+idx; read data captured at the edge
  // WR    | mem_write asserted at dst+idx with the captured word (or fill pattern)
  // DONE  | one-cycle done pulse, error if the request was out of range
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t           r_state;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_idx;

  logic [32:0]      w_src_end;
  logic [32:0]      w_dst_end;
  logic             w_range_err;
  logic             w_last;
  logic [LEN_W-1:0] w_idx_nxt;
  logic             w_fill_req;
  logic             w_fill_q;
  logic [31:0]      w_fill_data;

`ifdef MEM_COPY_FILL_EN
  logic        r_fill;
  logic [31:0] r_pat;
  assign w_fill_req  = i_fill;
  assign w_fill_q    = r_fill;
  assign w_fill_data = r_pat;
`else
  assign w_fill_req  = 1'b0;
  assign w_fill_q    = 1'b0;
  assign w_fill_data = 32'd0;
`endif

  // 33-bit sums so a source or destination near 2^32 cannot wrap into range
  assign w_src_end   = {1'b0, i_src_addr} + 33'(i_length);
  assign w_dst_end   = {1'b0, i_dst_addr} + 33'(i_length);
  assign w_range_err = (w_dst_end > 33'(DEPTH)) || (!w_fill_req && (w_src_end > 33'(DEPTH)));
  assign w_last      = (r_idx == r_len - LEN_W'(1));
  assign w_idx_nxt   = r_idx + LEN_W'(1);

  // Outputs are registered: each branch loads the values for the state being entered.
  // o_mem_write_data doubles as the read buffer in copy mode.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state          <= S_IDLE;
      r_src            <= '0;
      r_dst            <= '0;
      r_len            <= '0;
      r_idx            <= '0;
`ifdef MEM_COPY_FILL_EN
      r_fill           <= 1'b0;
      r_pat            <= '0;
`endif
      o_mem_address    <= '0;
      o_mem_write_data <= '0;
      o_mem_write      <= 1'b0;
      o_mem_read       <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_error          <= 1'b0;
    end else begin
      o_mem_address    <= '0;
      o_mem_write_data <= '0;
      o_mem_write      <= 1'b0;
      o_mem_read       <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_error          <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_src <= i_src_addr;
            r_dst <= i_dst_addr;
            r_len <= i_length;
            r_idx <= '0;
`ifdef MEM_COPY_FILL_EN
            r_fill <= i_fill;
            r_pat  <= i_fill_pattern;
`endif
            if (w_range_err) begin
              r_state <= S_DONE;
              o_done  <= 1'b1;
              o_error <= 1'b1;
            end else if (i_length == '0) begin
              r_state <= S_DONE;
              o_done  <= 1'b1;
            end else if (w_fill_req) begin
              r_state <= S_WR;
              o_busy  <= 1'b1;
              o_mem_write   <= 1'b1;
              o_mem_address <= i_dst_addr;
`ifdef MEM_COPY_FILL_EN
              o_mem_write_data <= i_fill_pattern;
`endif
            end else begin
              r_state       <= S_RD;
              o_busy        <= 1'b1;
              o_mem_read    <= 1'b1;
              o_mem_address <= i_src_addr;
            end
          end
        end
        S_RD: begin
          r_state          <= S_WR;
          o_busy           <= 1'b1;
          o_mem_write      <= 1'b1;
          o_mem_address    <= r_dst + 32'(r_idx);
          o_mem_write_data <= i_mem_read_data;
        end
        S_WR: begin
          if (w_last) begin
            r_state <= S_DONE;
            o_done  <= 1'b1;
          end else begin
            r_idx  <= w_idx_nxt;
            o_busy <= 1'b1;
            if (w_fill_q) begin
              r_state          <= S_WR;
              o_mem_write      <= 1'b1;
              o_mem_address    <= r_dst + 32'(w_idx_nxt);
              o_mem_write_data <= w_fill_data;
            end else begin
              r_state       <= S_RD;
              o_mem_read    <= 1'b1;
              o_mem_address <= r_src + 32'(w_idx_nxt);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: behavioural RAM, golden copy model and a write scoreboard.
// Define MEM_COPY_FILL_EN to also exercise the fill mode.
module tb_mem_copy_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [10:0] length;
`ifdef MEM_COPY_FILL_EN
  logic        fill;
  logic [31:0] fill_pat;
`endif
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        error;

  logic [31:0] ram  [1024];
  logic [31:0] gold [1024];
  logic [63:0] q_exp[$];

  int n_tests = 0;
  int n_fail  = 0;

  mem_copy_engine #(.DEPTH(1024), .LEN_W(11)) dut (
    .i_clk            (clk),
    .i_reset          (rst_n),
    .i_start          (start),
    .i_src_addr       (src_addr),
    .i_dst_addr       (dst_addr),
    .i_length         (length),
`ifdef MEM_COPY_FILL_EN
    .i_fill           (fill),
    .i_fill_pattern   (fill_pat),
`endif
    .o_mem_address    (mem_address),
    .o_mem_write_data (mem_wdata),
    .o_mem_write      (mem_write),
    .o_mem_read       (mem_read),
    .i_mem_read_data  (mem_rdata),
    .o_busy           (busy),
    .o_done           (done),
    .o_error          (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_address[9:0]];

  always @(posedge clk) begin
    if (mem_write) ram[mem_address[9:0]] <= mem_wdata;
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the next expected {address, data}.
  always @(negedge clk) begin
    if (rst_n) begin
      check("rd_wr_exclusive", 64'(mem_read & mem_write), 64'd0);
      if (!busy) check("idle_bus_zero", {mem_address, mem_wdata}, 64'd0);
      if (mem_write) begin
        if (q_exp.size() == 0) begin
          check("unexpected_write", {mem_address, mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check("write_addr_data", {mem_address, mem_wdata}, q_exp.pop_front());
        end
      end
    end
  end

  function automatic logic [31:0] pat_val(input logic [7:0] tag, input int i);
    logic [15:0] lo;
    lo = 16'(i);
    return {tag, 8'h5A, lo};
  endfunction

  task automatic preload(input logic [7:0] tag);
    for (int i = 0; i < 1024; i++) ram[i] <= pat_val(tag, i);
    @(negedge clk);
  endtask

  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input logic [10:0] len,
                          input logic use_fill, input logic [31:0] pat, input logic exp_err,
                          input int exp_lat, input string nm);
    int rd_cnt, wr_cnt, busy_cnt, got_lat, bad;
    logic got_err;
    logic [31:0] a, d;
    rd_cnt = 0; wr_cnt = 0; busy_cnt = 0; got_lat = -1; bad = 0; got_err = 1'b0;
    for (int i = 0; i < 1024; i++) gold[i] = ram[i];
    if (!exp_err) begin
      for (int k = 0; k < int'(len); k++) begin
        a = dst + 32'(k);
        d = use_fill ? pat : gold[10'(src + 32'(k))];
        q_exp.push_back({a, d});
        gold[a[9:0]] = d;
      end
    end
    src_addr = src; dst_addr = dst; length = len;
`ifdef MEM_COPY_FILL_EN
    fill = use_fill; fill_pat = pat;
`endif
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= exp_lat + 20; c++) begin
      @(negedge clk);
      if (mem_read)  rd_cnt++;
      if (mem_write) wr_cnt++;
      if (busy)      busy_cnt++;
      if (done) begin
        got_lat = c;
        got_err = error;
        break;
      end
    end
    check({nm, "_latency"}, 64'(got_lat), 64'(exp_lat));
    check({nm, "_error"}, 64'(got_err), 64'(exp_err));
    check({nm, "_reads"}, 64'(rd_cnt), (exp_err || use_fill) ? 64'd0 : 64'(len));
    check({nm, "_writes"}, 64'(wr_cnt), exp_err ? 64'd0 : 64'(len));
    check({nm, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
    @(negedge clk);
    check({nm, "_done_one_cycle"}, 64'(done), 64'd0);
    for (int i = 0; i < 1024; i++) if (ram[i] !== gold[i]) bad++;
    check({nm, "_ram_mismatches"}, 64'(bad), 64'd0);
    check({nm, "_sb_leftover"}, 64'(q_exp.size()), 64'd0);
    q_exp.delete();
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [10:0] len;
    logic        exp_err;
    int          exp_lat;
    string       nm;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] w10, w11, w402, w403, w500;
    int seen_done;
    vecs[0] = '{32'd10,   32'd100,  11'd4,    1'b0, 9,    "basic4"};
    vecs[1] = '{32'd5,    32'd200,  11'd0,    1'b0, 1,    "len0"};
    vecs[2] = '{32'd1020, 32'd0,    11'd5,    1'b1, 1,    "src_oor"};
    vecs[3] = '{32'd1019, 32'd300,  11'd5,    1'b0, 11,   "src_edge"};
    vecs[4] = '{32'd0,    32'd1020, 11'd5,    1'b1, 1,    "dst_oor"};
    vecs[5] = '{32'd1000, 32'd1021, 11'd3,    1'b0, 7,    "dst_edge"};
    vecs[6] = '{32'd0,    32'd0,    11'd1024, 1'b0, 2049, "full_depth"};

    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
`ifdef MEM_COPY_FILL_EN
    fill = 1'b0; fill_pat = '0;
`endif
    #12;
    check("reset_outputs", {mem_address, 32'(mem_wdata[3:0]), 28'd0}, 64'd0);
    check("reset_flags", 64'({mem_write, mem_read, busy, done, error}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      preload(8'(v + 1));
      run_copy(vecs[v].src, vecs[v].dst, vecs[v].len, 1'b0, 32'd0,
               vecs[v].exp_err, vecs[v].exp_lat, vecs[v].nm);
    end

    // Overlapping dst>src copy propagates the first word forward.
    preload(8'h20);
    ram[0] <= 32'd1; ram[1] <= 32'd2; ram[2] <= 32'd3; ram[3] <= 32'd4;
    @(negedge clk);
    run_copy(32'd0, 32'd1, 11'd3, 1'b0, 32'd0, 1'b0, 7, "overlap");
    for (int i = 0; i < 4; i++) check("overlap_word", 64'(ram[i]), 64'd1);

    // Reset during the write of word 2, with a start pulse while busy.
    preload(8'h30);
    w10 = pat_val(8'h30, 10); w11 = pat_val(8'h30, 11);
    w402 = pat_val(8'h30, 402); w403 = pat_val(8'h30, 403); w500 = pat_val(8'h30, 500);
    q_exp.push_back({32'd400, w10});
    q_exp.push_back({32'd401, w11});
    q_exp.push_back({32'd402, pat_val(8'h30, 12)});
    src_addr = 32'd10; dst_addr = 32'd400; length = 11'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 2) begin src_addr = 32'd0; dst_addr = 32'd500; length = 11'd2; start = 1'b1; end
      if (c == 3) start = 1'b0;
    end
    check("abort_in_wr2", {31'd0, mem_write, mem_address}, {31'd0, 1'b1, 32'd402});
    #1 rst_n = 1'b0;
    #1;
    check("abort_outputs_zero", {mem_address, mem_wdata}, 64'd0);
    check("abort_flags_zero", 64'({mem_write, mem_read, busy, done, error}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    check("abort_no_done", 64'(seen_done), 64'd0);
    check("abort_word0", 64'(ram[400]), 64'(w10));
    check("abort_word1", 64'(ram[401]), 64'(w11));
    check("abort_word2_kept", 64'(ram[402]), 64'(w402));
    check("abort_word3_kept", 64'(ram[403]), 64'(w403));
    check("ignored_start_dst", 64'(ram[500]), 64'(w500));
    check("abort_sb_leftover", 64'(q_exp.size()), 64'd0);
    q_exp.delete();

`ifdef MEM_COPY_FILL_EN
    preload(8'h40);
    run_copy(32'd2000, 32'd50, 11'd3, 1'b1, 32'hDEADBEEF, 1'b0, 4, "fill");
    for (int i = 50; i < 53; i++) check("fill_word", 64'(ram[i]), 64'hDEADBEEF);
    fill = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
